// File: rtl/key_pkg.sv
// key_pkg: shared constants for the key_loader front end of keyStorage.
//
// Contents:
//   - Key index constants KEY_PRIV..KEY_Y, matching the writeEnable bit of
//     each key register in keyStorage.
//   - Slice width (32), sliceSelector width (5), keySelect and writeEnable
//     widths, and the width of a word count (up to 32).
//   - key_words(): number of 32-bit slices of a key register.
//   - key_is_valid(): keySelect names one of the five key registers.
package key_pkg;

    localparam int SLICE_W     = 32;
    localparam int SLICE_SEL_W = 5;
    localparam int KEY_SEL_W   = 3;
    localparam int WE_W        = 6;
    localparam int WORD_CNT_W  = 6;

    localparam logic [KEY_SEL_W-1:0] KEY_PRIV = 3'd0;
    localparam logic [KEY_SEL_W-1:0] KEY_Q    = 3'd1;
    localparam logic [KEY_SEL_W-1:0] KEY_P    = 3'd2;
    localparam logic [KEY_SEL_W-1:0] KEY_G    = 3'd3;
    localparam logic [KEY_SEL_W-1:0] KEY_Y    = 3'd4;

    function automatic logic key_is_valid(input logic [KEY_SEL_W-1:0] sel);
        return sel <= KEY_Y;
    endfunction

    // Invalid selects return 0; callers reject them before using the count.
    function automatic logic [WORD_CNT_W-1:0] key_words(input logic [KEY_SEL_W-1:0] sel);
        case (sel)
            KEY_PRIV:            return 6'd4;
            KEY_Q:               return 6'd5;
            KEY_P, KEY_G, KEY_Y: return 6'd32;
            default:             return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/key_loader.sv
// key_loader: sequences a stream of 32-bit words into one keyStorage key
// register, generating keyInput / one-hot writeEnable / sliceSelector.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start, keySelect      load command (sampled in IDLE only); 5..7 -> error
//   wordData, wordValid   word stream, slice 0 first
//   wordReady             word accepted on an edge where wordValid is high
//   keyInput, writeEnable, sliceSelector
//                         registered keyStorage write bus, one cycle after
//                         acceptance; writeEnable is zero otherwise
//   busy                  high in LOAD and DONE
//   done                  one-cycle pulse the cycle after the last strobe
//   error                 one-cycle pulse on invalid keySelect or timeout
//
// Configuration:
//   KEY_LOADER_TIMEOUT_EN  when defined, a 16-bit idle counter aborts a LOAD
//                          that sees TIMEOUT_CYCLES cycles without a word.
//                          When undefined, LOAD waits indefinitely.
module key_loader
    import key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_SEL_W-1:0]   keySelect,
    input  logic [SLICE_W-1:0]     wordData,
    input  logic                   wordValid,
    output logic                   wordReady,
    output logic [SLICE_W-1:0]     keyInput,
    output logic [WE_W-1:0]        writeEnable,
    output logic [SLICE_SEL_W-1:0] sliceSelector,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e                  state_q;
    logic [KEY_SEL_W-1:0]    target_q;
    logic [WORD_CNT_W-1:0]   count_q;
    logic [SLICE_SEL_W-1:0]  index_q;
    logic [SLICE_W-1:0]      key_q;
    logic [WE_W-1:0]         we_q;
    logic [SLICE_SEL_W-1:0]  slice_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic accept;
    logic last_word;

    assign accept    = ready_q && wordValid;
    assign last_word = ({1'b0, index_q} == count_q - 6'd1);

`ifdef KEY_LOADER_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        timeout;

    // Fires on the edge that would bring the idle count to TIMEOUT_CYCLES.
    assign timeout = ready_q && !wordValid && (idle_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
`endif

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            count_q  <= '0;
            index_q  <= '0;
            key_q    <= '0;
            we_q     <= '0;
            slice_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef KEY_LOADER_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            // Strobes and pulses are single-cycle unless re-armed below.
            we_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (key_is_valid(keySelect)) begin
                            target_q <= keySelect;
                            count_q  <= key_words(keySelect);
                            index_q  <= '0;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ST_LOAD;
`ifdef KEY_LOADER_TIMEOUT_EN
                            idle_q   <= '0;
`endif
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        key_q   <= wordData;
                        slice_q <= index_q;
                        we_q    <= WE_W'(1) << target_q;
                        index_q <= index_q + 5'd1;
`ifdef KEY_LOADER_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                        if (last_word) begin
                            ready_q <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
`ifdef KEY_LOADER_TIMEOUT_EN
                    else if (timeout) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
`endif
                end

                // The last strobe is on the bus this cycle; done follows it.
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wordReady     = ready_q;
    assign keyInput      = key_q;
    assign writeEnable   = we_q;
    assign sliceSelector = slice_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule
